// File: rtl/wb_pwm_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pwm_pkg
// Purpose : Shared constants for the multi-channel Wishbone PWM peripheral:
//           register word offsets, CTRL bit positions, channel-count limit
//           and the byte-lane merge helper used for register writes.
// Revision: 1.0 - initial release
// ============================================================================
package pwm_pkg;

   // Maximum supported channel count (channel blocks occupy 0x00..0x7F)
   localparam int c_MAX_NCH = 8;

   // Word offset inside a channel block (byte address bits [3:2])
   localparam logic [1:0] c_REG_CTRL   = 2'd0;
   localparam logic [1:0] c_REG_PERIOD = 2'd1;
   localparam logic [1:0] c_REG_DUTY   = 2'd2;
   localparam logic [1:0] c_REG_COUNT  = 2'd3;

   // Global registers as word addresses (byte address bits [7:2])
   localparam logic [5:0] c_ADR_PRESC    = 6'h20;  // 0x80
   localparam logic [5:0] c_ADR_IRQ_STAT = 6'h21;  // 0x84
   localparam logic [5:0] c_ADR_IRQ_EN   = 6'h22;  // 0x88

   // CTRL bit indices
   localparam int c_CTRL_EN   = 0;
   localparam int c_CTRL_POL  = 1;
   localparam int c_CTRL_MODE = 2;

   // Replace only the byte lanes enabled in sel
   function automatic logic [31:0] merge_sel(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_pwm_multi_channel.sv
`default_nettype none
// ============================================================================
// Module  : pwm_channel
// Purpose : One PWM channel: counter, shadowed period/duty and registered
//           output. Optional center-aligned mode under PWM_CENTER_ALIGN_EN.
// Ports   : clk, rst        - clock, asynchronous active-high reset
//           i_mode          - center-aligned select (only with the macro)
//           i_tick          - shared prescaler tick
//           i_en, i_pol     - CTRL.EN / CTRL.POL
//           i_period,i_duty - live PERIOD / DUTY register values
//           o_pwm           - registered PWM output
//           o_wrap          - one-cycle pulse on the period wrap event
//           o_cnt           - current counter value
// Revision: 1.0 - initial release
// ============================================================================
module pwm_channel #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
`ifdef PWM_CENTER_ALIGN_EN
   input  logic          i_mode,
`endif
   input  logic          i_tick,
   input  logic          i_en,
   input  logic          i_pol,
   input  logic [CW-1:0] i_period,
   input  logic [CW-1:0] i_duty,
   output logic          o_pwm,
   output logic          o_wrap,
   output logic [CW-1:0] o_cnt
);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_per_s;
   logic [CW-1:0] r_duty_s;
   logic          r_pwm;
   logic          w_wrap;

`ifdef PWM_CENTER_ALIGN_EN
   logic          r_down;

   // Center mode wraps at 0 on the way down; per_s==0 wraps on every tick
   assign w_wrap = i_en && i_tick &&
                   (i_mode ? ((r_cnt == '0) && (r_down || (r_per_s == '0)))
                           : (r_cnt == r_per_s));
`else
   assign w_wrap = i_en && i_tick && (r_cnt == r_per_s);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_per_s  <= '0;
         r_duty_s <= '0;
         r_pwm    <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
         r_down   <= 1'b0;
`endif
      end else if (!i_en) begin
         // IDLE: shadows follow the registers so RUN starts with fresh values
         r_cnt    <= '0;
         r_per_s  <= i_period;
         r_duty_s <= i_duty;
         r_pwm    <= i_pol;
`ifdef PWM_CENTER_ALIGN_EN
         r_down   <= 1'b0;
`endif
      end else begin
         r_pwm <= (r_cnt < r_duty_s) ^ i_pol;
         if (w_wrap) begin
            r_per_s  <= i_period;
            r_duty_s <= i_duty;
`ifdef PWM_CENTER_ALIGN_EN
            r_down   <= 1'b0;
            // Count 0 was consumed by the wrap tick itself, resume at 1
            r_cnt    <= (i_mode && (i_period != '0)) ? CW'(1) : '0;
`else
            r_cnt    <= '0;
`endif
         end else if (i_tick) begin
`ifdef PWM_CENTER_ALIGN_EN
            if (i_mode && !r_down && (r_cnt >= r_per_s)) begin
               r_down <= 1'b1;
               r_cnt  <= r_cnt - CW'(1);
            end else if (i_mode && r_down) begin
               r_cnt  <= r_cnt - CW'(1);
            end else begin
               r_cnt  <= r_cnt + CW'(1);
            end
`else
            r_cnt <= r_cnt + CW'(1);
`endif
         end
      end
   end

   assign o_pwm  = r_pwm;
   assign o_wrap = w_wrap;
   assign o_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/wb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module  : wb_pwm_multi
// Purpose : Multi-channel PWM behind a Wishbone classic slave. Holds the bus
//           decode, register file, shared prescaler and period-wrap IRQ.
// Ports   : wb_clk_i, wb_rst_i (async, active-high)
//           wbs_cyc/stb/we/sel/adr/dat_i, wbs_ack_o, wbs_dat_o - Wishbone
//           pwm_o[NCH]   - PWM outputs
//           pwm_oeb[NCH] - pad output-enable-bar (~CTRL.EN)
//           irq_o        - |(IRQ_STAT & IRQ_EN)
// Config  : PWM_CENTER_ALIGN_EN enables CTRL.MODE (center-aligned counting).
// Revision: 1.0 - initial release
// ============================================================================
module wb_pwm_multi #(
   parameter int NCH = 4,
   parameter int CW  = 16
) (
   input  logic           wb_clk_i,
   input  logic           wb_rst_i,
   input  logic           wbs_cyc_i,
   input  logic           wbs_stb_i,
   input  logic           wbs_we_i,
   input  logic [3:0]     wbs_sel_i,
   input  logic [31:0]    wbs_adr_i,
   input  logic [31:0]    wbs_dat_i,
   output logic           wbs_ack_o,
   output logic [31:0]    wbs_dat_o,
   output logic [NCH-1:0] pwm_o,
   output logic [NCH-1:0] pwm_oeb,
   output logic           irq_o
);
   import pwm_pkg::*;

`ifdef PWM_CENTER_ALIGN_EN
   localparam logic [2:0] c_CTRL_MASK = 3'b111;
`else
   localparam logic [2:0] c_CTRL_MASK = 3'b011;
`endif

   logic [2:0]     r_ctrl   [NCH];
   logic [CW-1:0]  r_period [NCH];
   logic [CW-1:0]  r_duty   [NCH];
   logic [CW-1:0]  w_cnt    [NCH];
   logic [15:0]    r_presc;
   logic [15:0]    r_presc_cnt;
   logic [NCH-1:0] r_irq_stat;
   logic [NCH-1:0] r_irq_en;
   logic           r_ack;
   logic [31:0]    r_dat;

   logic           w_access;
   logic           w_wr;
   logic [5:0]     w_word;
   logic [1:0]     w_reg;
   logic           w_is_ch;
   logic [NCH-1:0] w_ch_sel;
   logic [31:0]    w_rdata;
   logic [31:0]    w_merged;
   logic [NCH-1:0] w_w1c;
   logic [NCH-1:0] w_wrap;
   logic           w_tick;
   logic           w_unused;

   // ---------------- Wishbone decode ----------------
   assign w_access = wbs_cyc_i && wbs_stb_i && !r_ack;
   assign w_wr     = w_access && wbs_we_i;
   assign w_word   = wbs_adr_i[7:2];
   assign w_reg    = w_word[1:0];
   assign w_is_ch  = !w_word[5] && (int'(w_word[4:2]) < NCH);
   assign w_unused = ^{wbs_adr_i[31:8], wbs_adr_i[1:0], w_merged};

   always_comb begin
      w_rdata = '0;
      for (int n = 0; n < NCH; n++) begin
         if (w_ch_sel[n]) begin
            case (w_reg)
               c_REG_CTRL:   w_rdata = 32'(r_ctrl[n]);
               c_REG_PERIOD: w_rdata = 32'(r_period[n]);
               c_REG_DUTY:   w_rdata = 32'(r_duty[n]);
               default:      w_rdata = 32'(w_cnt[n]);
            endcase
         end
      end
      case (w_word)
         c_ADR_PRESC:    w_rdata = 32'(r_presc);
         c_ADR_IRQ_STAT: w_rdata = 32'(r_irq_stat);
         c_ADR_IRQ_EN:   w_rdata = 32'(r_irq_en);
         default:        ;
      endcase
   end

   // Read-modify-write view of the addressed register for partial writes
   assign w_merged = merge_sel(w_rdata, wbs_dat_i, wbs_sel_i);

   // NCH <= 8 so all IRQ_STAT bits live in byte lane 0
   assign w_w1c = (w_wr && (w_word == c_ADR_IRQ_STAT) && wbs_sel_i[0])
                  ? wbs_dat_i[NCH-1:0] : '0;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_ack <= 1'b0;
         r_dat <= '0;
      end else begin
         r_ack <= w_access;
         r_dat <= (w_access && !wbs_we_i) ? w_rdata : '0;
      end
   end

   // ---------------- Register file ----------------
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         for (int n = 0; n < NCH; n++) begin
            r_ctrl[n]   <= '0;
            r_period[n] <= '0;
            r_duty[n]   <= '0;
         end
         r_presc  <= '0;
         r_irq_en <= '0;
      end else if (w_wr) begin
         for (int n = 0; n < NCH; n++) begin
            if (w_ch_sel[n]) begin
               case (w_reg)
                  c_REG_CTRL:   r_ctrl[n]   <= w_merged[2:0] & c_CTRL_MASK;
                  c_REG_PERIOD: r_period[n] <= w_merged[CW-1:0];
                  c_REG_DUTY:   r_duty[n]   <= w_merged[CW-1:0];
                  default:      ;
               endcase
            end
         end
         if (w_word == c_ADR_PRESC)  r_presc  <= w_merged[15:0];
         if (w_word == c_ADR_IRQ_EN) r_irq_en <= w_merged[NCH-1:0];
      end
   end

   // Hardware set takes priority over a simultaneous W1C
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) r_irq_stat <= '0;
      else          r_irq_stat <= w_wrap | (r_irq_stat & ~w_w1c);
   end

   // ---------------- Prescaler ----------------
   // >= rather than == so lowering PRESC below the running count recovers
   // at once instead of rolling through the full 16-bit range
   assign w_tick = (r_presc_cnt >= r_presc);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)    r_presc_cnt <= '0;
      else if (w_tick) r_presc_cnt <= '0;
      else             r_presc_cnt <= r_presc_cnt + 16'd1;
   end

   // ---------------- Channels ----------------
   for (genvar n = 0; n < NCH; n++) begin : g_ch
      assign w_ch_sel[n] = w_is_ch && (w_word[4:2] == 3'(n));
      assign pwm_oeb[n]  = ~r_ctrl[n][c_CTRL_EN];

      pwm_channel #(.CW(CW)) u_ch (
         .clk      (wb_clk_i),
         .rst      (wb_rst_i),
`ifdef PWM_CENTER_ALIGN_EN
         .i_mode   (r_ctrl[n][c_CTRL_MODE]),
`endif
         .i_tick   (w_tick),
         .i_en     (r_ctrl[n][c_CTRL_EN]),
         .i_pol    (r_ctrl[n][c_CTRL_POL]),
         .i_period (r_period[n]),
         .i_duty   (r_duty[n]),
         .o_pwm    (pwm_o[n]),
         .o_wrap   (w_wrap[n]),
         .o_cnt    (w_cnt[n])
      );
   end

   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_dat;
   assign irq_o     = |(r_irq_stat & r_irq_en);

endmodule
`default_nettype wire
